// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and mode constants.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// Single combinational full-adder bit, reused every cycle by the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes WIDTH bits LSB
// first behind a start/done handshake, reporting carry-out and signed overflow.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic             load;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  assign last_bit = (cnt == LAST);

  fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state logic; load marks the edge on which new operands are accepted.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand/result shift registers, carry flop, bit counter and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= (sub == SUB) ? ~b : b;
      carry <= (sub == SUB) ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum   <= {fa_s, sum[WIDTH-1:1]};
      carry <= fa_co;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      if (last_bit) begin
        cout <= fa_co;
        ovf  <= carry ^ fa_co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Handshake flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 2 and 16 with a result
// scoreboard plus timing, back-to-back, ignored-start and reset scenarios.
module tb_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub_in = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        cin_in = 1'b0;
  logic [1:0]  sel = 2'd0;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  logic start8, start2, start16;
  logic busy8, done8, cout8, ovf8;
  logic busy2, done2, cout2, ovf2;
  logic busy16, done16, cout16, ovf16;
  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [15:0] sum16;

  logic        cur_busy, cur_done, cur_cout, cur_ovf;
  logic [15:0] cur_sum;

  assign start8  = start & (sel == 2'd0);
  assign start2  = start & (sel == 2'd1);
  assign start16 = start & (sel == 2'd2);

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub_in),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub_in),
    .a(a_in[1:0]), .b(b_in[1:0]), .cin(cin_in),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub_in),
    .a(a_in), .b(b_in), .cin(cin_in),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // Route the selected DUT's outputs onto one set of observation signals.
  always_comb begin
    cur_busy = busy8;
    cur_done = done8;
    cur_sum  = {8'h00, sum8};
    cur_cout = cout8;
    cur_ovf  = ovf8;
    case (sel)
      2'd1: begin
        cur_busy = busy2;
        cur_done = done2;
        cur_sum  = {14'h0, sum2};
        cur_cout = cout2;
        cur_ovf  = ovf2;
      end
      2'd2: begin
        cur_busy = busy16;
        cur_done = done16;
        cur_sum  = sum16;
        cur_cout = cout16;
        cur_ovf  = ovf16;
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Arithmetic reference: plain integer add on masked operands.
  function automatic exp_t model(input int w, input logic s, input logic [15:0] a,
                                 input logic [15:0] b, input logic c);
    exp_t        r;
    logic [16:0] mask;
    logic [16:0] aa;
    logic [16:0] bb;
    logic [16:0] full;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & mask;
    bb   = s ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
    full = aa + bb + {16'h0, (s ? 1'b1 : c)};
    r.sum  = full[15:0] & mask[15:0];
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input logic [15:0] a, input logic [15:0] b,
                                input logic c, input exp_t e);
    sub_in = s;
    a_in   = a;
    b_in   = b;
    cin_in = c;
    start  = 1'b1;
    exp_q.push_back(e);
  endtask

  // Called in the cycle right after the accepting edge; returns in the done cycle.
  task automatic wait_done(input int w, input int glitch_at, input string tag);
    int n = 0;
    int bc = 0;
    while (!cur_done && n < 4 * w + 8) begin
      if (cur_busy) bc++;
      if (n == glitch_at) begin
        start  = 1'b1;
        a_in   = 16'h5A5A;
        b_in   = 16'h3C3C;
        sub_in = ~sub_in;
      end
      tick();
      start = 1'b0;
      n++;
    end
    check({tag, "_latency"}, n, w);
    check({tag, "_busy_cycles"}, bc, w);
    check({tag, "_busy_with_done"}, {31'h0, cur_busy}, 32'h0);
  endtask

  task automatic run_op(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input exp_t e, input int glitch_at, input string tag);
    apply_stimulus(s, a, b, c, e);
    tick();
    start = 1'b0;
    wait_done(w, glitch_at, tag);
    tick();
    check({tag, "_done_pulse"}, {31'h0, cur_done}, 32'h0);
    check({tag, "_idle_busy"}, {31'h0, cur_busy}, 32'h0);
    check({tag, "_sum_held"}, {16'h0, cur_sum}, {16'h0, e.sum});
  endtask

  // Scoreboard: every done pulse retires the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && cur_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_sum", {16'h0, cur_sum}, {16'h0, e.sum});
        check("sb_cout", {31'h0, cur_cout}, {31'h0, e.cout});
        check("sb_ovf", {31'h0, cur_ovf}, {31'h0, e.ovf});
      end
    end
  end

  task automatic run_width(input logic [1:0] s_sel, input int w, input vec_t tbl[8]);
    int   g;
    int   k;
    exp_t e;
    logic [15:0] ra, rb;
    logic        rs, rc;
    sel = s_sel;
    tick();

    for (int i = 0; i < 8; i++) begin
      e = (w == 8) ? tbl[i].e : model(w, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c);
      run_op(w, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c, e, -1, $sformatf("w%0d_vec%0d", w, i));
    end

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      run_op(w, rs, ra, rb, rc, model(w, rs, ra, rb, rc), -1, $sformatf("w%0d_rnd%0d", w, i));
    end

    g = (w - 1 < 2) ? w - 1 : 2;
    run_op(w, 1'b0, 16'h000F, 16'h0001, 1'b0, model(w, 1'b0, 16'h000F, 16'h0001, 1'b0), g,
           $sformatf("w%0d_ignored_start", w));

    apply_stimulus(1'b0, 16'h0003, 16'h0005, 1'b0, model(w, 1'b0, 16'h0003, 16'h0005, 1'b0));
    tick();
    start = 1'b0;
    wait_done(w, -1, $sformatf("w%0d_b2b_first", w));
    apply_stimulus(1'b0, 16'h0010, 16'h0020, 1'b0, model(w, 1'b0, 16'h0010, 16'h0020, 1'b0));
    tick();
    start = 1'b0;
    check($sformatf("w%0d_b2b_no_idle", w), {31'h0, cur_busy}, 32'h1);
    wait_done(w, -1, $sformatf("w%0d_b2b_second", w));
    tick();

    k = (w - 1 < 3) ? w - 1 : 3;
    apply_stimulus(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, model(w, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1));
    tick();
    start = 1'b0;
    repeat (k) tick();
    check($sformatf("w%0d_pre_reset_busy", w), {31'h0, cur_busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check($sformatf("w%0d_rst_busy", w), {31'h0, cur_busy}, 32'h0);
    check($sformatf("w%0d_rst_done", w), {31'h0, cur_done}, 32'h0);
    check($sformatf("w%0d_rst_sum", w), {16'h0, cur_sum}, 32'h0);
    check($sformatf("w%0d_rst_cout", w), {31'h0, cur_cout}, 32'h0);
    check($sformatf("w%0d_rst_ovf", w), {31'h0, cur_ovf}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(w, 1'b0, 16'h0001, 16'h0001, 1'b0, model(w, 1'b0, 16'h0001, 16'h0001, 1'b0), -1,
           $sformatf("w%0d_after_reset", w));
  endtask

  // Main sequence: reset check, then the full scenario set for each width.
  initial begin
    vec_t tbl[8];
    tbl[0] = '{s: 1'b0, a: 16'h0F, b: 16'h01, c: 1'b0, e: '{sum: 16'h10, cout: 1'b0, ovf: 1'b0}};
    tbl[1] = '{s: 1'b0, a: 16'hFF, b: 16'h01, c: 1'b1, e: '{sum: 16'h01, cout: 1'b1, ovf: 1'b0}};
    tbl[2] = '{s: 1'b0, a: 16'h7F, b: 16'h01, c: 1'b0, e: '{sum: 16'h80, cout: 1'b0, ovf: 1'b1}};
    tbl[3] = '{s: 1'b1, a: 16'h05, b: 16'h07, c: 1'b0, e: '{sum: 16'hFE, cout: 1'b0, ovf: 1'b0}};
    tbl[4] = '{s: 1'b1, a: 16'h80, b: 16'h01, c: 1'b0, e: '{sum: 16'h7F, cout: 1'b1, ovf: 1'b1}};
    tbl[5] = '{s: 1'b1, a: 16'h10, b: 16'h01, c: 1'b1, e: '{sum: 16'h0F, cout: 1'b1, ovf: 1'b0}};
    tbl[6] = '{s: 1'b0, a: 16'h3C, b: 16'h0A, c: 1'b1, e: '{sum: 16'h47, cout: 1'b0, ovf: 1'b0}};
    tbl[7] = '{s: 1'b0, a: 16'h80, b: 16'h80, c: 1'b0, e: '{sum: 16'h00, cout: 1'b1, ovf: 1'b1}};

    #2;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset_busy_%0d", s), {31'h0, cur_busy}, 32'h0);
      check($sformatf("reset_done_%0d", s), {31'h0, cur_done}, 32'h0);
      check($sformatf("reset_sum_%0d", s), {16'h0, cur_sum}, 32'h0);
      check($sformatf("reset_flags_%0d", s), {30'h0, cur_cout, cur_ovf}, 32'h0);
    end
    sel = 2'd0;
    tick();
    rst_n = 1'b1;
    tick();

    run_width(2'd0, 8, tbl);
    run_width(2'd1, 2, tbl);
    run_width(2'd2, 16, tbl);

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
